update_unpacker: RTL and testbench

- Reader side of the SSSP update stream. The SSSP core writes 512-bit lines, each holding eight 64-bit update entries, and reports the valid entry total in update_entry_count at done.
- This block takes those lines back, with the entry total for the pass, and emits entries to the 4-lane update-apply stage, up to 4 per cycle.
- The final partial line is trimmed so that exactly entry_count entries come out.
- Position: between the update-stream read DMA and the 4-lane apply pipelines.

---
 rtl/update_unpacker_pkg.sv | 30 +++
 rtl/update_unpacker_if.sv | 36 +++
 rtl/update_unpacker.sv | 148 ++++++++++++++
 tb/tb_update_unpacker.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/update_unpacker_pkg.sv
// Shared definitions for the SSSP update-stream reader: line geometry, FSM states
// and the contiguous lane-mask helper.
package update_stream_pkg;

    localparam int ENTRIES_PER_LINE = 8;
    localparam int LANES            = 4;
    localparam int LINE_W           = 512;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT_LO,
        EMIT_HI,
        FIN
    } state_e;

    // Low n bits set; n saturates at LANES.
    function automatic logic [LANES-1:0] lane_mask(input logic [2:0] n);
        logic [LANES-1:0] m;
        case (n)
            3'd0:    m = 4'b0000;
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/update_unpacker_if.sv
// Line-in / lane-out bus of the update unpacker. The slave modport is the
// unpacker itself; the master side is the read DMA plus the apply stage.
interface update_unpacker_if #(
    parameter int ENTRY_W = 64
);
    import update_stream_pkg::*;

    logic [LINE_W-1:0]        word_in;
    logic                     word_in_valid;
    logic                     word_in_ready;
    logic [LANES*ENTRY_W-1:0] lane_out;
    logic [LANES-1:0]         lane_valid;
    logic                     out_ready;
    logic                     last_out;

    modport slave (
        input  word_in,
        input  word_in_valid,
        input  out_ready,
        output word_in_ready,
        output lane_out,
        output lane_valid,
        output last_out
    );

    modport master (
        output word_in,
        output word_in_valid,
        output out_ready,
        input  word_in_ready,
        input  lane_out,
        input  lane_valid,
        input  last_out
    );

endinterface

// File: rtl/update_unpacker.sv
// Unpacks 8-entry update lines into up to 4 entries per beat for the apply lanes,
// trimming the final partial line so exactly entry_count entries are emitted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// LOAD    | waiting for the next line (word_in_ready=1)
// EMIT_LO | presenting slots 0..3 of the held line
// EMIT_HI | presenting slots 4..7; may accept the next line in parallel
// FIN     | pass complete, done raised, back to IDLE next cycle
module update_unpacker
    import update_stream_pkg::*;
#(
    parameter int COUNT_W = 32,
    parameter int ENTRY_W = 64    // fixed by the line format; only 64 is legal
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] entry_count,
    update_unpacker_if.slave   bus,
    output logic               done,
    output logic [COUNT_W-1:0] entries_emitted
);

    localparam int HALF_W = (ENTRIES_PER_LINE / 2) * ENTRY_W;

    state_e             r_state;
    state_e             w_state_next;
    logic [HALF_W-1:0]  r_line_hi;
    logic [HALF_W-1:0]  r_lane_out;
    logic [LANES-1:0]   r_lane_valid;
    logic               r_last;
    logic               r_done;
    logic [COUNT_W-1:0] r_remaining;
    logic [COUNT_W-1:0] r_emitted;

    logic [2:0]         w_beat_n;
    logic [COUNT_W-1:0] w_rem_after;
    logic [COUNT_W-1:0] w_rem_src;
    logic [2:0]         w_src_n;
    logic               w_fire;
    logic               w_load;
    logic               w_ready;

    function automatic logic [2:0] min4(input logic [COUNT_W-1:0] v);
        return (v >= COUNT_W'(4)) ? 3'd4 : v[2:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_fire       = 1'b0;
        w_load       = 1'b0;
        w_beat_n     = min4(r_remaining);
        w_rem_after  = r_remaining - COUNT_W'(w_beat_n);
        case (r_state)
            IDLE: begin
                if (start) w_state_next = (entry_count == '0) ? FIN : LOAD;
            end
            LOAD: begin
                w_ready = 1'b1;
                if (bus.word_in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = EMIT_LO;
                end
            end
            EMIT_LO: begin
                if (bus.out_ready) begin
                    w_fire       = 1'b1;
                    w_state_next = (w_rem_after == '0) ? FIN : EMIT_HI;
                end
            end
            EMIT_HI: begin
                // Overlapped fetch keeps one line per two cycles when the DMA keeps up.
                w_ready = bus.out_ready && (w_rem_after != '0);
                if (bus.out_ready) begin
                    w_fire = 1'b1;
                    if (w_rem_after == '0) begin
                        w_state_next = FIN;
                    end else if (bus.word_in_valid) begin
                        w_load       = 1'b1;
                        w_state_next = EMIT_LO;
                    end else begin
                        w_state_next = LOAD;
                    end
                end
            end
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        w_rem_src = w_fire ? w_rem_after : r_remaining;
        w_src_n   = min4(w_rem_src);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_hi    <= '0;
            r_lane_out   <= '0;
            r_lane_valid <= '0;
            r_last       <= 1'b0;
            r_done       <= 1'b0;
            r_remaining  <= '0;
            r_emitted    <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_remaining <= entry_count;
                r_emitted   <= '0;
                r_done      <= 1'b0;
            end
            if (w_fire) begin
                r_remaining <= w_rem_after;
                r_emitted   <= r_emitted + COUNT_W'(w_beat_n);
            end
            if (w_state_next == FIN && r_state != FIN) r_done <= 1'b1;

            // Beat registers are loaded one cycle ahead so every lane output is a flop.
            if (w_load) begin
                r_line_hi    <= bus.word_in[LINE_W-1 -: HALF_W];
                r_lane_out   <= bus.word_in[HALF_W-1:0];
                r_lane_valid <= lane_mask(w_src_n);
                r_last       <= (w_rem_src <= COUNT_W'(4));
            end else if (w_fire) begin
                if (w_state_next == EMIT_HI) begin
                    r_lane_out   <= r_line_hi;
                    r_lane_valid <= lane_mask(w_src_n);
                    r_last       <= (w_rem_src <= COUNT_W'(4));
                end else begin
                    r_lane_valid <= '0;
                    r_last       <= 1'b0;
                end
            end
        end
    end

    assign bus.word_in_ready = w_ready;
    assign bus.lane_out      = r_lane_out;
    assign bus.lane_valid    = r_lane_valid;
    assign bus.last_out      = r_last;
    assign done              = r_done;
    assign entries_emitted   = r_emitted;

endmodule

// File: tb/tb_update_unpacker.sv
// Directed bench for update_unpacker: a line feeder, a beat scoreboard filled from
// a reference unpacking model, and per-step checks of status and stall behaviour.
module tb_update_unpacker;
    import update_stream_pkg::*;

    typedef struct {
        logic [3:0]   valid;
        logic         last;
        logic [255:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] entry_count = '0;
    logic        done;
    logic [31:0] entries_emitted;

    update_unpacker_if #(.ENTRY_W(64)) bus();

    update_unpacker #(.COUNT_W(32), .ENTRY_W(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .entry_count     (entry_count),
        .bus             (bus),
        .done            (done),
        .entries_emitted (entries_emitted)
    );

    always #5 clk = ~clk;

    beat_t        exp_q[$];
    logic [511:0] line_q[$];
    int           beat_cyc[$];
    int           n_pass = 0;
    int           n_chk = 0;
    int           cyc = 0;
    int           lines_acc = 0;
    bit           feed_acc;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Read-DMA model: offers queued lines back to back.
    initial begin
        bus.word_in_valid = 1'b0;
        bus.word_in       = '0;
        forever begin
            @(negedge clk);
            feed_acc = bus.word_in_valid && bus.word_in_ready && !rst;
            @(posedge clk);
            #2;
            if (feed_acc && line_q.size() > 0) begin
                void'(line_q.pop_front());
                lines_acc++;
            end
            bus.word_in_valid = (line_q.size() > 0);
            bus.word_in       = (line_q.size() > 0) ? line_q[0] : '0;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.lane_valid != 4'b0000 && bus.out_ready) begin
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("beat_unexpected", {252'd0, bus.lane_valid}, 256'd0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_valid", {252'd0, bus.lane_valid}, {252'd0, e.valid});
                chk("beat_last", {255'd0, bus.last_out}, {255'd0, e.last});
                chk("beat_data", bus.lane_out, e.data);
            end
        end
    end

    // Reference: queue nlines lines (slot i of line j = base+8j+i) and the beats
    // that count entries should produce from them.
    task automatic expect_pass(input int count, input int nlines, input logic [63:0] base);
        int rem;
        rem = count;
        for (int j = 0; j < nlines; j++) begin
            logic [511:0] ln;
            for (int i = 0; i < 8; i++) ln[64*i +: 64] = base + 64'(j*8 + i);
            line_q.push_back(ln);
            for (int h = 0; h < 2; h++) begin
                if (rem > 0) begin
                    int    n;
                    beat_t b;
                    n       = (rem > 4) ? 4 : rem;
                    b.data  = ln[256*h +: 256];
                    b.valid = 4'((1 << n) - 1);
                    b.last  = (rem <= 4);
                    exp_q.push_back(b);
                    rem -= n;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int count);
        entry_count = 32'(count);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int k;
        k = 0;
        while (done !== 1'b1 && k < maxc) begin
            tick();
            k++;
        end
        chk({tag, "_done"}, {255'd0, done}, 256'd1);
    endtask

    task automatic wait_beat(input string tag, input int maxc);
        int k;
        k = 0;
        while (bus.lane_valid === 4'b0000 && k < maxc) begin
            tick();
            k++;
        end
        chk({tag, "_beat_seen"}, {255'd0, (bus.lane_valid != 4'b0000)}, 256'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] snap_data;
        logic [3:0]   snap_valid;
        logic         snap_last;
        int           done_at;

        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_lane_valid", {252'd0, bus.lane_valid}, 256'd0);
        chk("rst_lane_out", bus.lane_out, 256'd0);
        chk("rst_last", {255'd0, bus.last_out}, 256'd0);
        chk("rst_done", {255'd0, done}, 256'd0);
        chk("rst_emitted", {224'd0, entries_emitted}, 256'd0);
        chk("rst_ready", {255'd0, bus.word_in_ready}, 256'd0);
        rst = 1'b0;
        tick();

        // One full line.
        bus.out_ready = 1'b1;
        lines_acc = 0;
        expect_pass(8, 1, 64'h100);
        do_start(8);
        wait_done("t1", 40);
        chk("t1_emitted", {224'd0, entries_emitted}, 256'd8);
        chk("t1_scoreboard_empty", 256'(exp_q.size()), 256'd0);
        chk("t1_lines", 256'(lines_acc), 256'd1);
        repeat (2) tick();

        // 11 entries, three lines offered; third must never be taken.
        lines_acc = 0;
        expect_pass(11, 3, 64'h200);
        do_start(11);
        wait_done("t2", 40);
        repeat (4) tick();
        chk("t2_emitted", {224'd0, entries_emitted}, 256'd11);
        chk("t2_scoreboard_empty", 256'(exp_q.size()), 256'd0);
        chk("t2_lines", 256'(lines_acc), 256'd2);
        chk("t2_ready_after", {255'd0, bus.word_in_ready}, 256'd0);
        line_q.delete();
        tick();

        // Empty pass.
        done_at = -1;
        do_start(0);
        for (int k = 1; k <= 4; k++) begin
            if (done === 1'b1 && done_at < 0) done_at = k;
            chk("t3_ready", {255'd0, bus.word_in_ready}, 256'd0);
            chk("t3_lane_valid", {252'd0, bus.lane_valid}, 256'd0);
            tick();
        end
        chk("t3_done_by_2", {255'd0, (done_at >= 1 && done_at <= 2)}, 256'd1);
        chk("t3_emitted", {224'd0, entries_emitted}, 256'd0);

        // Stall on the first beat.
        bus.out_ready = 1'b0;
        expect_pass(5, 1, 64'h300);
        do_start(5);
        wait_beat("t4", 20);
        snap_data  = bus.lane_out;
        snap_valid = bus.lane_valid;
        snap_last  = bus.last_out;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_hold_data", bus.lane_out, snap_data);
            chk("t4_hold_valid", {252'd0, bus.lane_valid}, {252'd0, snap_valid});
            chk("t4_hold_last", {255'd0, bus.last_out}, {255'd0, snap_last});
        end
        bus.out_ready = 1'b1;
        wait_done("t4", 40);
        chk("t4_emitted", {224'd0, entries_emitted}, 256'd5);
        chk("t4_scoreboard_empty", 256'(exp_q.size()), 256'd0);
        repeat (2) tick();

        // Throughput with overlapped fetch.
        lines_acc = 0;
        beat_cyc.delete();
        expect_pass(16, 3, 64'h400);
        do_start(16);
        wait_done("t5", 40);
        repeat (3) tick();
        chk("t5_beats", 256'(beat_cyc.size()), 256'd4);
        if (beat_cyc.size() == 4)
            chk("t5_consecutive", 256'(beat_cyc[3] - beat_cyc[0]), 256'd3);
        chk("t5_lines", 256'(lines_acc), 256'd2);
        chk("t5_emitted", {224'd0, entries_emitted}, 256'd16);
        chk("t5_scoreboard_empty", 256'(exp_q.size()), 256'd0);
        line_q.delete();
        tick();

        // Reset while stalled in EMIT_HI, then a fresh short pass.
        bus.out_ready = 1'b0;
        expect_pass(16, 2, 64'h500);
        do_start(16);
        wait_beat("t6", 20);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t6_in_hi", {252'd0, bus.lane_valid}, 256'hf);
        exp_q.delete();
        line_q.delete();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("t6_rst_lane_valid", {252'd0, bus.lane_valid}, 256'd0);
        chk("t6_rst_lane_out", bus.lane_out, 256'd0);
        chk("t6_rst_last", {255'd0, bus.last_out}, 256'd0);
        chk("t6_rst_done", {255'd0, done}, 256'd0);
        chk("t6_rst_emitted", {224'd0, entries_emitted}, 256'd0);
        chk("t6_rst_ready", {255'd0, bus.word_in_ready}, 256'd0);
        rst = 1'b0;
        tick();
        beat_cyc.delete();
        expect_pass(4, 1, 64'h600);
        do_start(4);
        wait_done("t6b", 40);
        chk("t6b_beats", 256'(beat_cyc.size()), 256'd1);
        chk("t6b_emitted", {224'd0, entries_emitted}, 256'd4);
        chk("t6b_scoreboard_empty", 256'(exp_q.size()), 256'd0);
        line_q.delete();
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
